// File: rtl/txpybuf_rd.sv
// txpybuf_rd: fetches tx payload words from SRAM and serialises them LSB-first, one bit per advance.
module txpybuf_rd #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        txbuf_st_p,
  input  logic [12:0] pylenbit,
  input  logic [7:0]  txbuf_base,
  input  logic        pybit_adv_p,
  input  logic        abort_p,
  input  logic [31:0] txpydout,
  output logic        txpyrd_p,
  output logic [7:0]  txpyadr,
  output logic        bufpacketin,
  output logic        txbuf_ready,
  output logic        txbuf_busy,
  output logic        txbuf_done_p,
  output logic        txbuf_underrun
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  logic [1:0] state;
  logic [12:0] plen, bit_cnt;
  logic [7:0] base;
  logic [8:0] nwords, issued;
  logic [31:0] cur, nxt;
  logic cur_vld, nxt_vld;
  logic [RD_LAT-1:0] pipe;
  logic [13:0] plen_rnd;
  logic dv, last, bound;
  assign plen_rnd = {1'b0, pylenbit} + 14'd31;
  assign dv = pipe[RD_LAT-1];
  assign last = bit_cnt == plen - 13'd1;
  assign bound = bit_cnt[4:0] == 5'd31;
  assign txbuf_ready = state == RUN;
  assign txbuf_busy = state != IDLE;
  assign bufpacketin = txbuf_busy & cur[0];
  // pipe tracks strobes in flight; clearing it discards any read data still returning
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state <= IDLE;
      plen <= '0;
      bit_cnt <= '0;
      base <= '0;
      nwords <= '0;
      issued <= '0;
      cur <= '0;
      nxt <= '0;
      cur_vld <= 1'b0;
      nxt_vld <= 1'b0;
      pipe <= '0;
      txpyrd_p <= 1'b0;
      txpyadr <= '0;
      txbuf_done_p <= 1'b0;
      txbuf_underrun <= 1'b0;
    end else begin
      txpyrd_p <= 1'b0;
      txbuf_done_p <= 1'b0;
      pipe <= (pipe << 1) | RD_LAT'(txpyrd_p);
      if (txbuf_st_p) txbuf_underrun <= 1'b0;
      if (abort_p) begin
        state <= IDLE;
        pipe <= '0;
      end else if (txbuf_st_p && pylenbit != 13'd0) begin
        state <= LOAD;
        plen <= pylenbit;
        base <= txbuf_base;
        nwords <= plen_rnd[13:5];
        issued <= 9'd1;
        txpyrd_p <= 1'b1;
        txpyadr <= txbuf_base;
        bit_cnt <= '0;
        cur <= '0;
        nxt <= '0;
        cur_vld <= 1'b0;
        nxt_vld <= 1'b0;
        pipe <= '0;
      end else if (state == LOAD) begin
        if (pybit_adv_p) begin
          txbuf_underrun <= 1'b1;
          state <= IDLE;
          pipe <= '0;
        end else begin
          if (issued == 9'd1 && nwords > 9'd1) begin
            txpyrd_p <= 1'b1;
            txpyadr <= base + 8'd1;
            issued <= 9'd2;
          end
          if (dv) begin
            if (!cur_vld) begin
              cur <= txpydout;
              cur_vld <= 1'b1;
            end else begin
              nxt <= txpydout;
              nxt_vld <= 1'b1;
            end
            if (cur_vld || nwords == 9'd1) state <= RUN;
          end
        end
      end else if (state == RUN) begin
        if (dv) begin
          nxt <= txpydout;
          nxt_vld <= 1'b1;
        end
        if (pybit_adv_p) begin
          if (last) begin
            state <= IDLE;
            txbuf_done_p <= 1'b1;
            pipe <= '0;
          end else if (bound && !nxt_vld) begin
            txbuf_underrun <= 1'b1;
            state <= IDLE;
            pipe <= '0;
          end else begin
            bit_cnt <= bit_cnt + 13'd1;
            cur <= bound ? nxt : cur >> 1;
            if (bound) begin
              nxt_vld <= 1'b0;
              if (issued < nwords) begin
                txpyrd_p <= 1'b1;
                txpyadr <= base + issued[7:0];
                issued <= issued + 9'd1;
              end
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_txpybuf_rd.sv
// tb_txpybuf_rd: drives two readers (RD_LAT 1 and 3) from a shared SRAM model and checks one at a time.
module tb_txpybuf_rd;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, st = 1'b0, adv = 1'b0, abort = 1'b0;
  logic [12:0] len = '0;
  logic [7:0] base = '0;
  logic [31:0] dout [2];
  logic rd [2], bit_o [2], rdy [2], busy [2], done [2], und [2];
  logic [7:0] adr [2];
  logic [31:0] mem [256];
  logic [7:0] h0;
  logic [7:0] h1 [3];
  int sel = 0, checks = 0, errors = 0, done_cnt = 0, rdy_cyc = 0;
  logic [7:0] adr_q [$];
  logic got [$];
  logic last_done;

  txpybuf_rd #(.RD_LAT(1)) u0 (.clk_6M(clk), .rst(rst), .txbuf_st_p(st), .pylenbit(len), .txbuf_base(base),
    .pybit_adv_p(adv), .abort_p(abort), .txpydout(dout[0]), .txpyrd_p(rd[0]), .txpyadr(adr[0]),
    .bufpacketin(bit_o[0]), .txbuf_ready(rdy[0]), .txbuf_busy(busy[0]), .txbuf_done_p(done[0]),
    .txbuf_underrun(und[0]));
  txpybuf_rd #(.RD_LAT(3)) u1 (.clk_6M(clk), .rst(rst), .txbuf_st_p(st), .pylenbit(len), .txbuf_base(base),
    .pybit_adv_p(adv), .abort_p(abort), .txpydout(dout[1]), .txpyrd_p(rd[1]), .txpyadr(adr[1]),
    .bufpacketin(bit_o[1]), .txbuf_ready(rdy[1]), .txbuf_busy(busy[1]), .txbuf_done_p(done[1]),
    .txbuf_underrun(und[1]));

  // SRAM model: data for a strobe in cycle S appears in cycle S+latency
  always @(posedge clk) begin
    h0 <= adr[0];
    h1[0] <= adr[1];
    h1[1] <= h1[0];
    h1[2] <= h1[1];
  end
  assign dout[0] = mem[h0];
  assign dout[1] = mem[h1[2]];

  always @(negedge clk) begin
    if (rd[sel]) adr_q.push_back(adr[sel]);
    if (done[sel]) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] b, input logic [12:0] l);
    base = b;
    len = l;
    st = 1'b1;
    tick;
    st = 1'b0;
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  task automatic stream(input int nadv, input int gap);
    got.delete();
    rdy_cyc = 1;
    while (!rdy[sel] && rdy_cyc < 20) begin
      tick;
      rdy_cyc++;
    end
    for (int i = 0; i < nadv; i++) begin
      got.push_back(bit_o[sel]);
      adv = 1'b1;
      tick;
      adv = 1'b0;
      last_done = done[sel];
      if (i < nadv - 1) repeat (gap - 1) tick;
    end
  endtask

  function automatic int first_bad(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      automatic logic [7:0] a = b + 8'(i >> 5);
      if (i >= got.size() || got[i] !== mem[a][i & 31]) return i;
    end
    return -1;
  endfunction

  function automatic bit addr_ok(input logic [7:0] b, input int n);
    if (adr_q.size() != n) return 1'b0;
    for (int k = 0; k < n; k++) if (adr_q[k] !== 8'(b + k)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rd[k], adr[k], bit_o[k], rdy[k], busy[k], done[k], und[k]} !== 14'd0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got %h exp 0", k,
                 {rd[k], adr[k], bit_o[k], rdy[k], busy[k], done[k], und[k]});
      end
    end
    rst = 1'b0;
    fill_mem;
    start(8'h40, 13'd200);
    repeat (6) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({busy[0], rdy[0], rd[0], adr[0], bit_o[0]} !== 12'd0) begin
      errors++;
      $display("FAIL reset_midxfer got %h exp 0", {busy[0], rdy[0], rd[0], adr[0], bit_o[0]});
    end
    tick;
  endtask

  task automatic test_basic;
    int bad;
    sel = 0;
    mem[8'h10] = 32'h0F0F_A5A5;
    mem[8'h11] = 32'h1234_5678;
    mem[8'h12] = 32'h0000_00C3;
    adr_q.delete();
    done_cnt = 0;
    start(8'h10, 13'd72);
    checks++;
    if (rd[0] !== 1'b1 || adr[0] !== 8'h10) begin
      errors++;
      $display("FAIL first_strobe got rd=%b adr=%h exp rd=1 adr=10", rd[0], adr[0]);
    end
    stream(72, 3);
    checks++;
    if (rdy_cyc != 4) begin errors++; $display("FAIL ready_time got %0d exp 4", rdy_cyc); end
    bad = first_bad(8'h10, 72);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL basic_bits first bad idx %0d exp none", bad); end
    checks++;
    if (last_done !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b exp 1 0", last_done, busy[0]);
    end
    tick;
    checks++;
    if (done_cnt != 1 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL done_width got cnt=%0d now=%b exp 1 0", done_cnt, done[0]);
    end
    checks++;
    if (!addr_ok(8'h10, 3)) begin errors++; $display("FAIL basic_addr got %0d strobes exp 3 at 10..12", adr_q.size()); end
  endtask

  task automatic test_wrap;
    int bad;
    sel = 0;
    fill_mem;
    adr_q.delete();
    start(8'hF0, 13'd8168);
    stream(8168, 6);
    bad = first_bad(8'hF0, 8168);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL wrap_bits first bad idx %0d exp none", bad); end
    checks++;
    if (!addr_ok(8'hF0, 256)) begin errors++; $display("FAIL wrap_addr got %0d strobes exp 256 from f0", adr_q.size()); end
    checks++;
    if (last_done !== 1'b1 || und[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end got done=%b und=%b exp 1 0", last_done, und[0]);
    end
    tick;
  endtask

  task automatic test_lat3;
    int bad;
    logic [7:0] b;
    sel = 1;
    fill_mem;
    adr_q.delete();
    b = 8'($urandom);
    start(b, 13'd100);
    stream(100, 2);
    checks++;
    if (rdy_cyc != 6) begin errors++; $display("FAIL lat3_ready got %0d exp 6", rdy_cyc); end
    bad = first_bad(b, 100);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL lat3_bits first bad idx %0d exp none", bad); end
    checks++;
    if ({got[99], got[98], got[97], got[96]} !== mem[8'(b + 3)][3:0]) begin
      errors++;
      $display("FAIL lat3_tail got %b exp %b", {got[99], got[98], got[97], got[96]}, mem[8'(b + 3)][3:0]);
    end
    checks++;
    if (!addr_ok(b, 4) || und[1] !== 1'b0 || last_done !== 1'b1) begin
      errors++;
      $display("FAIL lat3_end got strobes=%0d und=%b done=%b exp 4 0 1", adr_q.size(), und[1], last_done);
    end
    tick;
  endtask

  task automatic test_underrun;
    sel = 0;
    done_cnt = 0;
    start(8'h33, 13'd64);
    adv = 1'b1;
    tick;
    adv = 1'b0;
    checks++;
    if (und[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL underrun_flag got und=%b busy=%b exp 1 0", und[0], busy[0]);
    end
    repeat (6) tick;
    checks++;
    if (done_cnt != 0 || und[0] !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got done=%0d und=%b exp 0 1", done_cnt, und[0]);
    end
    start(8'h33, 13'd33);
    checks++;
    if (und[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL underrun_clear got und=%b busy=%b exp 0 1", und[0], busy[0]);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    int bad, n;
    logic [7:0] b;
    sel = 0;
    fill_mem;
    adr_q.delete();
    done_cnt = 0;
    b = 8'($urandom);
    start(b, 13'd128);
    stream(40, 3);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b rdy=%b exp 0 0", busy[0], rdy[0]);
    end
    bad = first_bad(b, 40);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL abort_bits first bad idx %0d exp none", bad); end
    n = adr_q.size();
    repeat (10) tick;
    checks++;
    if (adr_q.size() != 3 || n != 3 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_quiet got strobes=%0d done=%0d exp 3 0", adr_q.size(), done_cnt);
    end
    abort = 1'b1;
    start(b, 13'd64);
    abort = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_st_busy got %b exp 0", busy[0]); end
    repeat (5) tick;
    checks++;
    if (adr_q.size() != 3) begin errors++; $display("FAIL abort_st_strobes got %0d exp 3", adr_q.size()); end
  endtask

  task automatic test_short;
    int bad;
    logic any_busy;
    logic [7:0] b;
    sel = 0;
    fill_mem;
    adr_q.delete();
    b = 8'($urandom);
    start(b, 13'd0);
    any_busy = busy[0];
    repeat (5) begin
      tick;
      any_busy |= busy[0];
    end
    checks++;
    if (any_busy !== 1'b0 || adr_q.size() != 0) begin
      errors++;
      $display("FAIL zero_len got busy=%b strobes=%0d exp 0 0", any_busy, adr_q.size());
    end
    start(b, 13'd33);
    stream(33, 3);
    checks++;
    if (got[32] !== mem[8'(b + 1)][0]) begin errors++; $display("FAIL len33_bit32 got %b exp %b", got[32], mem[8'(b + 1)][0]); end
    bad = first_bad(b, 33);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL len33_bits first bad idx %0d exp none", bad); end
    checks++;
    if (!addr_ok(b, 2) || last_done !== 1'b1) begin
      errors++;
      $display("FAIL len33_end got strobes=%0d done=%b exp 2 1", adr_q.size(), last_done);
    end
    tick;
  endtask

  task automatic test_restart;
    int bad, l, nw;
    logic [7:0] b;
    sel = 1;
    fill_mem;
    start(8'($urandom), 13'd64);
    stream(10, 2);
    adr_q.delete();
    b = 8'($urandom);
    l = 1 + int'($urandom_range(199));
    nw = (l + 31) / 32;
    start(b, 13'(l));
    stream(l, 3);
    checks++;
    if (rdy_cyc != (nw > 1 ? 6 : 5)) begin errors++; $display("FAIL restart_ready got %0d exp %0d", rdy_cyc, nw > 1 ? 6 : 5); end
    bad = first_bad(b, l);
    checks++;
    if (bad != -1) begin errors++; $display("FAIL restart_bits first bad idx %0d exp none", bad); end
    checks++;
    if (!addr_ok(b, nw) || last_done !== 1'b1) begin
      errors++;
      $display("FAIL restart_end got strobes=%0d done=%b exp %0d 1", adr_q.size(), last_done, nw);
    end
    tick;
  endtask

  task automatic test_random;
    int bad, l, nw, gap, exp_rdy;
    logic [7:0] b;
    for (int it = 0; it < 6; it++) begin
      sel = int'($urandom_range(1));
      fill_mem;
      adr_q.delete();
      b = 8'($urandom);
      l = 1 + int'($urandom_range(299));
      gap = 2 + int'($urandom_range(3));
      nw = (l + 31) / 32;
      exp_rdy = (nw > 1 ? 3 : 2) + (sel == 1 ? 3 : 1);
      start(b, 13'(l));
      stream(l, gap);
      checks++;
      if (rdy_cyc != exp_rdy) begin errors++; $display("FAIL rand_ready it%0d got %0d exp %0d", it, rdy_cyc, exp_rdy); end
      bad = first_bad(b, l);
      checks++;
      if (bad != -1) begin errors++; $display("FAIL rand_bits it%0d first bad idx %0d exp none", it, bad); end
      checks++;
      if (!addr_ok(b, nw) || last_done !== 1'b1 || und[sel] !== 1'b0) begin
        errors++;
        $display("FAIL rand_end it%0d got strobes=%0d done=%b und=%b exp %0d 1 0", it, adr_q.size(), last_done, und[sel], nw);
      end
      tick;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset;
    test_basic;
    test_wrap;
    test_lat3;
    test_underrun;
    test_abort;
    test_short;
    test_restart;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
